// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Seven-segment patterns and BCD helpers shared by the counter.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Elaboration-time conversion of a decimal integer to 8-digit packed BCD
    function automatic logic [31:0] int_to_bcd(input int unsigned value);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One cascaded BCD digit stage with carry/borrow to the next digit.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       clr,
    input  logic [3:0] clr_to,
    output logic [3:0] d,
    output logic       carry,
    output logic       borrow
);

    logic [3:0] r_d;

    // Load beats wrap-jump, which beats increment/decrement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d <= 4'd0;
        end else if (ld) begin
            r_d <= ld_val;
        end else if (clr) begin
            r_d <= clr_to;
        end else if (inc) begin
            r_d <= (r_d == 4'd9) ? 4'd0 : r_d + 4'd1;
        end else if (dec) begin
            r_d <= (r_d == 4'd0) ? 4'd9 : r_d - 4'd1;
        end
    end

    assign d      = r_d;
    assign carry  = inc & (r_d == 4'd9);
    assign borrow = dec & (r_d == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter
// Purpose  : Multi-digit BCD up/down counter with prescaler, modulus, load
//            and per-digit seven-segment decode.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter
    import counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MAX    = 59,
    parameter int DIV    = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fast,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int                  c_PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0]     c_PRE_LAST  = c_PW'(DIV - 1);
    localparam logic [31:0]         c_MAX_BCD32 = int_to_bcd($unsigned(MAX));
    localparam logic [4*DIGITS-1:0] c_MAX_BCD   = c_MAX_BCD32[4*DIGITS-1:0];

    logic [c_PW-1:0]     r_presc;
    logic                r_wrap;
    logic                r_load_err;
    logic                w_tick;
    logic                w_step;
    logic                w_do_step;
    logic                w_at_max;
    logic                w_at_zero;
    logic                w_load_ok;
    logic                w_ld_acc;
    logic                w_ld_rej;
    logic                w_clr;
    logic [DIGITS-1:0]   w_nib_ok;
    logic [DIGITS:0]     w_inc;
    logic [DIGITS:0]     w_dec;
    logic [4*DIGITS-1:0] w_bcd;
    logic                w_unused_chain_out;

    // Prescaler: frozen while en=0, wraps to 0 after DIV-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    assign w_tick    = (r_presc == c_PRE_LAST);
    assign w_step    = en & (fast | w_tick);
    // Any load request, accepted or rejected, suppresses the step
    assign w_do_step = w_step & ~load;

    // Digits are always valid BCD, so packed compare equals numeric compare
    assign w_load_ok = (&w_nib_ok) && (load_bcd <= c_MAX_BCD);
    assign w_ld_acc  = load & w_load_ok;
    assign w_ld_rej  = load & ~w_load_ok;

    assign w_at_max  = (w_bcd == c_MAX_BCD);
    assign w_at_zero = (w_bcd == '0);
    assign w_clr     = w_do_step & (up ? w_at_max : w_at_zero);
    assign w_inc[0]  = w_do_step & up & ~w_at_max;
    assign w_dec[0]  = w_do_step & ~up & ~w_at_zero;

    // The chain never ripples out of the top digit; wraps are taken via w_clr
    assign w_unused_chain_out = w_inc[DIGITS] | w_dec[DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst),
                .inc    (w_inc[gi]),
                .dec    (w_dec[gi]),
                .ld     (w_ld_acc),
                .ld_val (load_bcd[4*gi +: 4]),
                .clr    (w_clr),
                .clr_to (up ? 4'd0 : c_MAX_BCD[4*gi +: 4]),
                .d      (w_bcd[4*gi +: 4]),
                .carry  (w_inc[gi+1]),
                .borrow (w_dec[gi+1])
            );
            assign w_nib_ok[gi]    = (load_bcd[4*gi +: 4] <= 4'd9);
            assign seg[7*gi +: 7]  = bcd_to_seg(w_bcd[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= w_clr;
            r_load_err <= w_ld_rej;
        end
    end

    assign bcd      = w_bcd;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bcd_updown_counter
// Purpose  : Scoreboard bench for bcd_updown_counter in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Config A: DIGITS=2 MAX=59 DIV=1
    logic        a_fast, a_en, a_up, a_load;
    logic [7:0]  a_load_bcd, a_bcd;
    logic [13:0] a_seg;
    logic        a_wrap, a_err;
    // Config B: DIGITS=2 MAX=59 DIV=4
    logic        b_fast, b_en, b_up, b_load;
    logic [7:0]  b_load_bcd, b_bcd;
    logic [13:0] b_seg;
    logic        b_wrap, b_err;
    // Config C: DIGITS=3 MAX=999 DIV=1
    logic        c_fast, c_en, c_up, c_load;
    logic [11:0] c_load_bcd, c_bcd;
    logic [20:0] c_seg;
    logic        c_wrap, c_err;

    bcd_updown_counter #(.DIGITS(2), .MAX(59), .DIV(1)) u_dut_a (
        .clk(clk), .rst(rst), .fast(a_fast), .en(a_en), .up(a_up), .load(a_load),
        .load_bcd(a_load_bcd), .bcd(a_bcd), .seg(a_seg), .wrap(a_wrap), .load_err(a_err));
    bcd_updown_counter #(.DIGITS(2), .MAX(59), .DIV(4)) u_dut_b (
        .clk(clk), .rst(rst), .fast(b_fast), .en(b_en), .up(b_up), .load(b_load),
        .load_bcd(b_load_bcd), .bcd(b_bcd), .seg(b_seg), .wrap(b_wrap), .load_err(b_err));
    bcd_updown_counter #(.DIGITS(3), .MAX(999), .DIV(1)) u_dut_c (
        .clk(clk), .rst(rst), .fast(c_fast), .en(c_en), .up(c_up), .load(c_load),
        .load_bcd(c_load_bcd), .bcd(c_bcd), .seg(c_seg), .wrap(c_wrap), .load_err(c_err));

    typedef struct {
        int          id;
        int          tag;
        logic [31:0] bcd;
        logic        wrap;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_tag   = 0;

    function automatic logic [6:0] seg_tab(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    function automatic logic [63:0] exp_seg(input logic [31:0] b, input int nd);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < nd; i++) s[7*i +: 7] = seg_tab(b[4*i +: 4]);
        return s;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s #%0d: got %0h expected %0h", name, tag, act, exp);
    endtask

    task automatic push(input int id, input logic [31:0] b, input logic w, input logic e);
        exp_t x;
        x.id = id; x.tag = n_tag; x.bcd = b; x.wrap = w; x.err = e;
        n_tag++;
        sb.push_back(x);
    endtask

    // Each drive_* applies inputs, lets one edge pass, then queues the expectation
    task automatic drive_a(input logic f, input logic e, input logic u, input logic l,
                           input logic [7:0] lv, input logic [7:0] eb, input logic ew, input logic ee);
        a_fast = f; a_en = e; a_up = u; a_load = l; a_load_bcd = lv;
        @(posedge clk); #1;
        push(0, 32'(eb), ew, ee);
    endtask

    task automatic drive_b(input logic e, input logic [7:0] eb);
        b_fast = 1'b0; b_en = e; b_up = 1'b1; b_load = 1'b0;
        @(posedge clk); #1;
        push(1, 32'(eb), 1'b0, 1'b0);
    endtask

    task automatic drive_c(input logic [11:0] eb, input logic ew);
        c_fast = 1'b1; c_en = 1'b1; c_up = 1'b1; c_load = 1'b0;
        @(posedge clk); #1;
        push(2, 32'(eb), ew, 1'b0);
    endtask

    // Monitor: outputs are stable mid-cycle, compare every queued expectation
    initial begin
        exp_t        e;
        logic [31:0] ab;
        logic [63:0] as;
        logic        aw, ae;
        int          nd;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.id)
                    0:       begin ab = 32'(a_bcd); as = 64'(a_seg); aw = a_wrap; ae = a_err; nd = 2; end
                    1:       begin ab = 32'(b_bcd); as = 64'(b_seg); aw = b_wrap; ae = b_err; nd = 2; end
                    default: begin ab = 32'(c_bcd); as = 64'(c_seg); aw = c_wrap; ae = c_err; nd = 3; end
                endcase
                chk("bcd",      e.tag, 64'(ab), 64'(e.bcd));
                chk("seg",      e.tag, as, exp_seg(e.bcd, nd));
                chk("wrap",     e.tag, 64'(aw), 64'(e.wrap));
                chk("load_err", e.tag, 64'(ae), 64'(e.err));
            end
        end
    end

    initial begin
        int p;
        int cnt;
        logic ben;
        rst = 1'b0;
        a_fast = 0; a_en = 0; a_up = 1; a_load = 0; a_load_bcd = '0;
        b_fast = 0; b_en = 0; b_up = 1; b_load = 0; b_load_bcd = '0;
        c_fast = 0; c_en = 0; c_up = 1; c_load = 0; c_load_bcd = '0;

        #12;
        chk("rst_bcd",  -1, 64'(a_bcd), 64'h0);
        chk("rst_seg",  -1, 64'(a_seg), 64'h1FBF);
        chk("rst_wrap", -1, 64'(a_wrap), 64'h0);
        chk("rst_err",  -1, 64'(a_err), 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Up-count through the modulus; 60th step wraps
        for (int k = 1; k <= 60; k++)
            drive_a(1, 1, 1, 0, 8'h00, 8'(to_bcd(k % 60)), (k == 60), 0);
        drive_a(0, 0, 1, 0, 8'h00, 8'h00, 0, 0);

        // Down-count: underflow to MAX, then borrow across digits
        drive_a(1, 1, 0, 0, 8'h00, 8'h59, 1, 0);
        drive_a(1, 1, 0, 0, 8'h00, 8'h58, 0, 0);
        drive_a(0, 0, 0, 1, 8'h50, 8'h50, 0, 0);
        drive_a(1, 1, 0, 0, 8'h00, 8'h49, 0, 0);

        // Loads: accepted, invalid digit, above MAX (twice in a row)
        drive_a(0, 0, 1, 1, 8'h37, 8'h37, 0, 0);
        drive_a(0, 0, 1, 1, 8'h3A, 8'h37, 0, 1);
        drive_a(0, 0, 1, 0, 8'h00, 8'h37, 0, 0);
        drive_a(0, 0, 1, 1, 8'h60, 8'h37, 0, 1);
        drive_a(0, 0, 1, 1, 8'h60, 8'h37, 0, 1);
        drive_a(0, 0, 1, 0, 8'h00, 8'h37, 0, 0);
        // Load together with a step that would wrap: load wins, no wrap
        drive_a(0, 0, 1, 1, 8'h59, 8'h59, 0, 0);
        drive_a(1, 1, 1, 1, 8'h12, 8'h12, 0, 0);
        drive_a(1, 1, 1, 0, 8'h00, 8'h13, 0, 0);

        // Asynchronous reset mid-count at 0x42
        drive_a(0, 0, 1, 1, 8'h42, 8'h42, 0, 0);
        a_load = 0; a_en = 0;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_bcd", -2, 64'(a_bcd), 64'h0);
        chk("arst_seg", -2, 64'(a_seg), 64'h1FBF);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_a(1, 1, 1, 0, 8'h00, 8'h01, 0, 0);
        drive_a(1, 1, 1, 0, 8'h00, 8'h02, 0, 0);

        // Prescaler DIV=4 with a 3-cycle enable gap
        p = 0;
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            ben = !(k >= 10 && k < 13);
            if (ben) begin
                if (p == 3) begin p = 0; cnt++; end
                else p++;
            end
            drive_b(ben, 8'(to_bcd(cnt)));
        end

        // Three digits through a full cycle of 1000 steps
        for (int k = 1; k <= 1000; k++)
            drive_c(12'(to_bcd(k % 1000)), (k == 1000));
        drive_c(12'h001, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("sb_drain", -3, 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
